// File: rtl/alu_input_sequencer.sv
// Four-step operand/opcode entry sequencer for a small switch-driven ALU.
// Debounced-by-sync buttons step A -> B -> op -> result; a mode button toggles hex/decimal display.
module alu_input_sequencer #(
  parameter int WIDTH      = 16,
  parameter int OUT_LENGTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [WIDTH-1:0]      SW,
  input  logic                  BTN_ENTER,
  input  logic                  BTN_MODE,
  output logic [OUT_LENGTH-1:0] BIN_OUT,
  output logic                  DEC_TRIGGER,
  output logic [1:0]            STATE,
  output logic [3:0]            FLAGS
);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RES = 2'b11
  } state_t;

  state_t state;

  logic enter_sync_p0, enter_sync_p1, enter_sync_p2;
  logic mode_sync_p0, mode_sync_p1, mode_sync_p2;
  logic fill_p0, fill_p1;
  logic enter_armed, mode_armed;
  logic enter_p, mode_p;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic [WIDTH:0]   result_reg;
  logic [3:0]       flags_reg;
  logic             dec_mode;

  // Raw WIDTH+1-bit result; subtraction keeps bit WIDTH clear and is sign-extended at the output.
  function automatic logic [WIDTH:0] alu_result(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       op);
    logic [WIDTH:0]   res;
    logic signed [WIDTH-1:0] diff;
    diff = signed'(a - b);
    case (op)
      2'b00:   res = {1'b0, a} + {1'b0, b};
      2'b01:   res = {1'b0, diff};
      2'b10:   res = {1'b0, a & b};
      default: res = {1'b0, a | b};
    endcase
    return res;
  endfunction

  function automatic logic [3:0] alu_flags(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [1:0]       op);
    logic [WIDTH:0]          sum;
    logic [WIDTH-1:0]        r;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic                    c;
    logic                    v;
    sa  = signed'(a);
    sb  = signed'(b);
    sum = {1'b0, a} + {1'b0, b};
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      2'b00: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (sa[WIDTH-1] == sb[WIDTH-1]) && (r[WIDTH-1] != sa[WIDTH-1]);
      end
      2'b01: begin
        r = a - b;
        c = (a < b);
        v = (sa[WIDTH-1] != sb[WIDTH-1]) && (r[WIDTH-1] != sa[WIDTH-1]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r[WIDTH-1], (r == '0), c, v};
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2: edge-detect history.
  // fill_p* marks the synchronizer as holding real samples so a button held
  // through reset is never mistaken for a fresh press.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      enter_sync_p0 <= 1'b0;
      enter_sync_p1 <= 1'b0;
      enter_sync_p2 <= 1'b0;
      mode_sync_p0  <= 1'b0;
      mode_sync_p1  <= 1'b0;
      mode_sync_p2  <= 1'b0;
      fill_p0       <= 1'b0;
      fill_p1       <= 1'b0;
      enter_armed   <= 1'b0;
      mode_armed    <= 1'b0;
    end else begin
      enter_sync_p0 <= BTN_ENTER;
      enter_sync_p1 <= enter_sync_p0;
      enter_sync_p2 <= enter_sync_p1;
      mode_sync_p0  <= BTN_MODE;
      mode_sync_p1  <= mode_sync_p0;
      mode_sync_p2  <= mode_sync_p1;
      fill_p0       <= 1'b1;
      fill_p1       <= fill_p0;
      if (fill_p1 && !enter_sync_p1) enter_armed <= 1'b1;
      if (fill_p1 && !mode_sync_p1)  mode_armed  <= 1'b1;
    end
  end

  assign enter_p = enter_sync_p1 & ~enter_sync_p2 & enter_armed;
  assign mode_p  = mode_sync_p1  & ~mode_sync_p2  & mode_armed;

  // Sequencer state, operands and registered ALU result.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_A;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= 2'b00;
      result_reg <= '0;
      flags_reg  <= 4'b0000;
      dec_mode   <= 1'b0;
    end else begin
      if (mode_p) dec_mode <= ~dec_mode;
      if (enter_p) begin
        case (state)
          S_A: begin
            a_reg <= SW;
            state <= S_B;
          end
          S_B: begin
            b_reg <= SW;
            state <= S_OP;
          end
          S_OP: begin
            op_reg     <= SW[1:0];
            result_reg <= alu_result(a_reg, b_reg, SW[1:0]);
            flags_reg  <= alu_flags(a_reg, b_reg, SW[1:0]);
            state      <= S_RES;
          end
          default: state <= S_A;
        endcase
      end
    end
  end

  always_comb begin
    BIN_OUT = '0;
    case (state)
      S_A, S_B: BIN_OUT = OUT_LENGTH'(SW);
      S_OP:     BIN_OUT = OUT_LENGTH'(SW[1:0]);
      default: begin
        if (op_reg == 2'b01)
          BIN_OUT = {{(OUT_LENGTH-WIDTH){result_reg[WIDTH-1]}}, result_reg[WIDTH-1:0]};
        else
          BIN_OUT = OUT_LENGTH'(result_reg);
      end
    endcase
  end

  assign STATE       = state;
  assign FLAGS       = (state == S_RES) ? flags_reg : 4'b0000;
  // Negative results go to the display in hex regardless of mode.
  assign DEC_TRIGGER = dec_mode & ~((state == S_RES) & flags_reg[3]);

endmodule
